// File: rtl/compare_arbiter_if.sv
// Bundle between the requesters, the shared comparator and compare_arbiter.
// The slave modport is the arbiter's view; master is the requester/comparator side.
interface compare_arbiter_if #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] a_in;
    logic [NREQ*WIDTH-1:0] b_in;
    logic [NREQ-1:0]       ack;
    logic                  res_lt;
    logic                  res_eq;
    logic                  res_gt;
    logic [IDW-1:0]        res_id;
    logic                  busy;
    logic                  err;
    logic [WIDTH-1:0]      cmp_a;
    logic [WIDTH-1:0]      cmp_b;
    logic                  cmp_lt;
    logic                  cmp_eq;
    logic                  cmp_gt;

    modport slave (
        input  req, a_in, b_in, cmp_lt, cmp_eq, cmp_gt,
        output ack, res_lt, res_eq, res_gt, res_id, busy, err, cmp_a, cmp_b
    );

    modport master (
        output req, a_in, b_in, cmp_lt, cmp_eq, cmp_gt,
        input  ack, res_lt, res_eq, res_gt, res_id, busy, err, cmp_a, cmp_b
    );
endinterface

// File: rtl/compare_arbiter.sv
// Round-robin sharing of one combinational comparator between NREQ requesters.
// state | meaning
// IDLE  | sample req, pick next requester, load comparator operands
// WAIT  | comparator settled: capture result, pulse ack, advance pointer
// DONE  | ack low again, return to IDLE
module compare_arbiter #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4
) (
    input  logic                clk,
    input  logic                rst,
    compare_arbiter_if.slave    bus
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0]   last_q, last_d;
    logic [WIDTH-1:0] cmp_a_q, cmp_a_d;
    logic [WIDTH-1:0] cmp_b_q, cmp_b_d;
    logic             res_lt_q, res_lt_d;
    logic             res_eq_q, res_eq_d;
    logic             res_gt_q, res_gt_d;
    logic [IDW-1:0]   res_id_q, res_id_d;
    logic [NREQ-1:0]  ack_q, ack_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;

    logic [IDW-1:0]   pick;
    logic             found;
    int               cand;
    logic [IDW-1:0]   cand_idx;
    logic             onehot;

    // Search upward from last+1 so the most recently served requester goes last.
    always_comb begin
        pick     = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand     = (int'(last_q) + i) % NREQ;
            cand_idx = IDW'(cand);
            if (!found && bus.req[cand_idx]) begin
                found = 1'b1;
                pick  = cand_idx;
            end
        end
    end

    assign onehot = ({bus.cmp_lt, bus.cmp_eq, bus.cmp_gt} == 3'b100) ||
                    ({bus.cmp_lt, bus.cmp_eq, bus.cmp_gt} == 3'b010) ||
                    ({bus.cmp_lt, bus.cmp_eq, bus.cmp_gt} == 3'b001);

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        last_d   = last_q;
        cmp_a_d  = cmp_a_q;
        cmp_b_d  = cmp_b_q;
        res_lt_d = res_lt_q;
        res_eq_d = res_eq_q;
        res_gt_d = res_gt_q;
        res_id_d = res_id_q;
        ack_d    = '0;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    gnt_d   = pick;
                    cmp_a_d = bus.a_in[int'(pick)*WIDTH +: WIDTH];
                    cmp_b_d = bus.b_in[int'(pick)*WIDTH +: WIDTH];
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                res_lt_d      = bus.cmp_lt;
                res_eq_d      = bus.cmp_eq;
                res_gt_d      = bus.cmp_gt;
                res_id_d      = gnt_q;
                ack_d[gnt_q]  = 1'b1;
                last_d        = gnt_q;
                if (!onehot) err_d = 1'b1;
                state_d       = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            gnt_q    <= '0;
            last_q   <= IDW'(NREQ - 1);
            cmp_a_q  <= '0;
            cmp_b_q  <= '0;
            res_lt_q <= 1'b0;
            res_eq_q <= 1'b0;
            res_gt_q <= 1'b0;
            res_id_q <= '0;
            ack_q    <= '0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            last_q   <= last_d;
            cmp_a_q  <= cmp_a_d;
            cmp_b_q  <= cmp_b_d;
            res_lt_q <= res_lt_d;
            res_eq_q <= res_eq_d;
            res_gt_q <= res_gt_d;
            res_id_q <= res_id_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

    assign bus.ack    = ack_q;
    assign bus.res_lt = res_lt_q;
    assign bus.res_eq = res_eq_q;
    assign bus.res_gt = res_gt_q;
    assign bus.res_id = res_id_q;
    assign bus.busy   = busy_q;
    assign bus.err    = err_q;
    assign bus.cmp_a  = cmp_a_q;
    assign bus.cmp_b  = cmp_b_q;
endmodule

// File: tb/tb_compare_arbiter.sv
// Directed bench for compare_arbiter with a behavioural unsigned comparator
// that can be forced to produce a non-one-hot result.
module tb_compare_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic force_bad = 1'b0;
    int   tests  = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    compare_arbiter_if #(.WIDTH(4), .NREQ(4)) bus();
    compare_arbiter #(.WIDTH(4), .NREQ(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    assign bus.cmp_lt = force_bad | (bus.cmp_a < bus.cmp_b);
    assign bus.cmp_gt = force_bad | (bus.cmp_a > bus.cmp_b);
    assign bus.cmp_eq = !force_bad & (bus.cmp_a == bus.cmp_b);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [3:0] a, input logic [3:0] b);
        bus.a_in[i*4 +: 4] = a;
        bus.b_in[i*4 +: 4] = b;
    endtask

    task automatic check_zero(input string tag);
        check(tag, {bus.ack, bus.busy, bus.err, bus.res_lt, bus.res_eq, bus.res_gt,
                    bus.res_id, bus.cmp_a, bus.cmp_b}, 32'h0);
    endtask

    // Called in IDLE with req already driven; walks E0 (sample), E1 (ack), E2 (idle).
    task automatic serve(input string tag, input int id, input logic [2:0] lt_eq_gt,
                         input logic [3:0] ea, input logic [3:0] eb,
                         input logic [3:0] drop_wait, input logic [3:0] drop_ack,
                         input logic [3:0] glitch, input logic bad, input logic exp_err);
        logic [3:0] exp_ack;
        exp_ack = 4'b0001 << id;
        cyc();
        check({tag, " E0 busy/ack"}, {bus.busy, bus.ack}, {1'b1, 4'b0000});
        check({tag, " E0 operands"}, {bus.cmp_a, bus.cmp_b}, {ea, eb});
        bus.req   = bus.req & ~drop_wait;
        force_bad = bad;
        cyc();
        force_bad = 1'b0;
        check({tag, " E1 ack"}, bus.ack, exp_ack);
        check({tag, " E1 result"}, {bus.res_lt, bus.res_eq, bus.res_gt}, lt_eq_gt);
        check({tag, " E1 res_id/busy/err"}, {bus.res_id, bus.busy, bus.err},
              {2'(id), 1'b1, exp_err});
        bus.req = (bus.req & ~drop_ack) | glitch;
        cyc();
        check({tag, " E2 ack/busy/err"}, {bus.ack, bus.busy, bus.err}, {4'b0000, 1'b0, exp_err});
        check({tag, " E2 result held"}, {bus.res_lt, bus.res_eq, bus.res_gt, bus.res_id},
              {lt_eq_gt, 2'(id)});
        bus.req = bus.req & ~glitch;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, failed);
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        bus.req  = '0;
        bus.a_in = '0;
        bus.b_in = '0;
        #1;
        check_zero("reset state");
        cyc();
        cyc();
        rst = 1'b0;

        // single requester: lt, eq, gt
        set_ops(0, 4'd3, 4'd9);
        bus.req = 4'b0001;
        serve("single lt", 0, 3'b100, 4'd3, 4'd9, 4'b0000, 4'b0001, 4'b0000, 1'b0, 1'b0);
        set_ops(0, 4'd9, 4'd9);
        bus.req = 4'b0001;
        serve("single eq", 0, 3'b010, 4'd9, 4'd9, 4'b0000, 4'b0001, 4'b0000, 1'b0, 1'b0);
        set_ops(0, 4'd15, 4'd0);
        bus.req = 4'b0001;
        serve("single gt", 0, 3'b001, 4'd15, 4'd0, 4'b0000, 4'b0001, 4'b0000, 1'b0, 1'b0);

        // fresh reset so the round-robin starts at 0 again
        rst = 1'b1;
        #1;
        check_zero("second reset");
        cyc();
        rst = 1'b0;

        // all four held: 0,1,2,3,0 back to back
        set_ops(0, 4'd1, 4'd2);
        set_ops(1, 4'd5, 4'd5);
        set_ops(2, 4'd7, 4'd4);
        set_ops(3, 4'd0, 4'd15);
        bus.req = 4'b1111;
        serve("rr0", 0, 3'b100, 4'd1, 4'd2,  4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        serve("rr1", 1, 3'b010, 4'd5, 4'd5,  4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        serve("rr2", 2, 3'b001, 4'd7, 4'd4,  4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        serve("rr3", 3, 3'b100, 4'd0, 4'd15, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        serve("rr0b", 0, 3'b100, 4'd1, 4'd2, 4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0);

        // serve 2, then 0101 must wrap past 3 to 0, then 2
        bus.req = 4'b0100;
        serve("wrap 2", 2, 3'b001, 4'd7, 4'd4, 4'b0000, 4'b0100, 4'b0000, 1'b0, 1'b0);
        bus.req = 4'b0101;
        serve("wrap 0", 0, 3'b100, 4'd1, 4'd2, 4'b0000, 4'b0001, 4'b0000, 1'b0, 1'b0);
        serve("wrap 2b", 2, 3'b001, 4'd7, 4'd4, 4'b0000, 4'b0100, 4'b0000, 1'b0, 1'b0);

        // non-one-hot comparator result sets sticky err, still acked
        bus.req = 4'b0010;
        serve("bad cmp", 1, 3'b101, 4'd5, 4'd5, 4'b0000, 4'b0010, 4'b0000, 1'b1, 1'b1);
        bus.req = 4'b0010;
        serve("err sticky", 1, 3'b010, 4'd5, 4'd5, 4'b0000, 4'b0010, 4'b0000, 1'b0, 1'b1);

        // reset in WAIT: no ack, outputs zero, pointer back to NREQ-1
        set_ops(0, 4'd6, 4'd2);
        bus.req = 4'b0001;
        cyc();
        check("rst-wait pre busy/operand", {bus.busy, bus.cmp_a, bus.cmp_b}, {1'b1, 4'd6, 4'd2});
        rst = 1'b1;
        #1;
        check_zero("rst in wait");
        bus.req = '0;
        cyc();
        check("rst hold ack", bus.ack, 4'b0000);
        cyc();
        check_zero("rst hold zero");
        rst = 1'b0;
        set_ops(0, 4'd2, 4'd8);
        bus.req = 4'b0101;
        serve("post-rst 0", 0, 3'b100, 4'd2, 4'd8, 4'b0000, 4'b0001, 4'b0000, 1'b0, 1'b0);
        serve("post-rst 2", 2, 3'b001, 4'd7, 4'd4, 4'b0000, 4'b0100, 4'b0000, 1'b0, 1'b0);

        // requester 1 drops during WAIT; req[3] glitch only during DONE
        set_ops(1, 4'd12, 4'd3);
        bus.req = 4'b0010;
        serve("drop in wait", 1, 3'b001, 4'd12, 4'd3, 4'b0010, 4'b0000, 4'b1000, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            check($sformatf("glitch ignored c%0d", k), {bus.busy, bus.ack}, {1'b0, 4'b0000});
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
